// File: rtl/recepcao_serial_bcd_if.sv
// Byte-in / BCD-out bundle of the serial frame parser.
//   master: UART RX side and consumer (drives dado_recebido/recebido, reads results)
//   slave : the parser (reads the byte strobe, drives digits, pulses and debug state)
interface recepcao_serial_bcd_if;
  logic [7:0] dado_recebido;
  logic       recebido;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       pronto;
  logic       erro;
  logic       ocupado;
  logic [3:0] db_estado;

  modport master (
    output dado_recebido, recebido,
    input  centena, dezena, unidade, pronto, erro, ocupado, db_estado
  );

  modport slave (
    input  dado_recebido, recebido,
    output centena, dezena, unidade, pronto, erro, ocupado, db_estado
  );
endinterface

// File: rtl/recepcao_serial_bcd.sv
// Receive-side parser for ASCII frames "DDD#" coming from the UART RX.
// Validates each frame and publishes three BCD digits with a one-cycle pronto
// pulse; rejected frames give a one-cycle erro pulse and keep the old digits.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - recepcao_serial_bcd_if.slave (dado_recebido, recebido in;
//            centena, dezena, unidade, pronto, erro, ocupado, db_estado out)
// Optional feature: define RECEPCAO_TIMEOUT_EN to build the inter-byte
// timeout (TIMEOUT_CICLOS idle cycles abort a partial frame).
module recepcao_serial_bcd #(
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  recepcao_serial_bcd_if.slave  bus
);

  typedef enum logic [3:0] {
    ESPERA_CENTENA = 4'b0000,
    ESPERA_DEZENA  = 4'b0001,
    ESPERA_UNIDADE = 4'b0010,
    ESPERA_HASHTAG = 4'b0011,
    FIM            = 4'b0100,
    FALHA          = 4'b1111
  } estado_t;

  localparam logic [7:0] HASHTAG = 8'h23;

  estado_t    r_estado;
  estado_t    w_prox;
  logic [3:0] r_sh_c, r_sh_d, r_sh_u;
  logic [3:0] r_centena, r_dezena, r_unidade;
  logic       r_pronto, r_erro, r_ocupado;
  logic       w_digito;
  logic       w_em_quadro;
  logic       w_timeout;
  logic       w_grava_c, w_grava_d, w_grava_u, w_publica;

  assign w_digito    = (bus.dado_recebido >= 8'h30) && (bus.dado_recebido <= 8'h39);
  assign w_em_quadro = (r_estado == ESPERA_DEZENA) || (r_estado == ESPERA_UNIDADE) ||
                       (r_estado == ESPERA_HASHTAG);

`ifdef RECEPCAO_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Idle-cycle counter; only runs while a frame is partially received.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!w_em_quadro || bus.recebido) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A strobe in the expiry cycle wins over the timeout.
  assign w_timeout = w_em_quadro && !bus.recebido &&
                     (r_cnt == CNT_W'(TIMEOUT_CICLOS - 1));
`else
  // No counter in this build: TIMEOUT_CICLOS has no effect.
  assign w_timeout = (TIMEOUT_CICLOS == 32'd0) && 1'b0;
`endif

  // Next state and shadow/publish strobes.
  always_comb begin
    w_prox    = r_estado;
    w_grava_c = 1'b0;
    w_grava_d = 1'b0;
    w_grava_u = 1'b0;
    w_publica = 1'b0;
    case (r_estado)
      // fim/falha last one cycle and evaluate a strobe like espera_centena.
      ESPERA_CENTENA, FIM, FALHA: begin
        w_prox = ESPERA_CENTENA;
        if (bus.recebido) begin
          if (w_digito) begin
            w_prox    = ESPERA_DEZENA;
            w_grava_c = 1'b1;
          end else if (bus.dado_recebido != HASHTAG) begin
            w_prox = FALHA;
          end
        end
      end
      ESPERA_DEZENA: begin
        if (bus.recebido) begin
          if (w_digito) begin
            w_prox    = ESPERA_UNIDADE;
            w_grava_d = 1'b1;
          end else begin
            w_prox = FALHA;
          end
        end else if (w_timeout) begin
          w_prox = FALHA;
        end
      end
      ESPERA_UNIDADE: begin
        if (bus.recebido) begin
          if (w_digito) begin
            w_prox    = ESPERA_HASHTAG;
            w_grava_u = 1'b1;
          end else begin
            w_prox = FALHA;
          end
        end else if (w_timeout) begin
          w_prox = FALHA;
        end
      end
      ESPERA_HASHTAG: begin
        if (bus.recebido) begin
          if (bus.dado_recebido == HASHTAG) begin
            w_prox    = FIM;
            w_publica = 1'b1;
          end else begin
            w_prox = FALHA;
          end
        end else if (w_timeout) begin
          w_prox = FALHA;
        end
      end
      default: w_prox = ESPERA_CENTENA;
    endcase
  end

  // State, shadow digits and registered Moore outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= ESPERA_CENTENA;
      r_sh_c    <= 4'd0;
      r_sh_d    <= 4'd0;
      r_sh_u    <= 4'd0;
      r_centena <= 4'd0;
      r_dezena  <= 4'd0;
      r_unidade <= 4'd0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_pronto  <= (w_prox == FIM);
      r_erro    <= (w_prox == FALHA);
      r_ocupado <= (w_prox == ESPERA_DEZENA) || (w_prox == ESPERA_UNIDADE) ||
                   (w_prox == ESPERA_HASHTAG);
      if (w_grava_c) r_sh_c <= bus.dado_recebido[3:0];
      if (w_grava_d) r_sh_d <= bus.dado_recebido[3:0];
      if (w_grava_u) r_sh_u <= bus.dado_recebido[3:0];
      if (w_publica) begin
        r_centena <= r_sh_c;
        r_dezena  <= r_sh_d;
        r_unidade <= r_sh_u;
      end
    end
  end

  assign bus.centena   = r_centena;
  assign bus.dezena    = r_dezena;
  assign bus.unidade   = r_unidade;
  assign bus.pronto    = r_pronto;
  assign bus.erro      = r_erro;
  assign bus.ocupado   = r_ocupado;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_recepcao_serial_bcd.sv
// Bench for recepcao_serial_bcd: byte-stream reference model feeding a
// scoreboard of expected pronto/erro events, plus directed state checks.
module tb_recepcao_serial_bcd;

  localparam int unsigned T = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  recepcao_serial_bcd_if bus ();

  recepcao_serial_bcd #(.TIMEOUT_CICLOS(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int ciclo = 0;
  always @(posedge clock) ciclo++;

  typedef struct {
    bit         eh_erro;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    int         borda;
  } evento_t;

  evento_t    fila[$];
  logic [3:0] pend[$];
  int         ultimo = 0;
  logic [3:0] mon_c = 4'd0, mon_d = 4'd0, mon_u = 4'd0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  function automatic void empilha(input bit eh_erro, input int borda);
    evento_t ev;
    ev.eh_erro = eh_erro;
    ev.borda   = borda;
    ev.c = 4'd0; ev.d = 4'd0; ev.u = 4'd0;
    if (!eh_erro) begin
      ev.c = pend[0]; ev.d = pend[1]; ev.u = pend[2];
    end
    fila.push_back(ev);
    pend.delete();
  endfunction

  // A partial frame with no strobe at edge ultimo+T times out on that edge.
  function automatic void modelo_timeout(input int horizonte);
    bit en;
`ifdef RECEPCAO_TIMEOUT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    if (en && pend.size() != 0 && ultimo + int'(T) < horizonte)
      empilha(1'b1, ultimo + int'(T));
  endfunction

  function automatic void modelo_byte(input logic [7:0] b, input int borda);
    bit dig;
    dig = (b >= 8'h30) && (b <= 8'h39);
    modelo_timeout(borda);
    if (pend.size() == 0) begin
      if (dig) begin pend.push_back(b[3:0]); ultimo = borda; end
      else if (b != 8'h23) empilha(1'b1, borda);
    end else if (pend.size() < 3) begin
      if (dig) begin pend.push_back(b[3:0]); ultimo = borda; end
      else empilha(1'b1, borda);
    end else begin
      empilha(b != 8'h23, borda);
    end
  endfunction

  // One strobe, then 'ocioso' idle cycles before the next byte may go out.
  task automatic envia(input logic [7:0] b, input int ocioso);
    int borda;
    @(negedge clock);
    bus.dado_recebido = b;
    bus.recebido      = 1'b1;
    borda = ciclo + 1;
    modelo_byte(b, borda);
    modelo_timeout(borda + ocioso + 1);
    if (ocioso > 0) begin
      @(negedge clock);
      bus.recebido = 1'b0;
      repeat (ocioso - 1) @(negedge clock);
    end
  endtask

  task automatic ocioso(input int n);
    modelo_timeout(ciclo + n + 2);
    @(negedge clock);
    bus.recebido = 1'b0;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic quadro(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input int g);
    envia(a, g); envia(b, g); envia(c, g); envia(d, g);
  endtask

  // Scoreboard monitor: every pronto/erro pulse must match the next expected event.
  always @(negedge clock) begin
    evento_t ev;
    if (reset) begin
      while (fila.size() != 0 && fila[0].borda < ciclo) begin
        ev = fila.pop_front();
        checks++; errors++;
        $display("FAIL missing_event: got none expected %s at edge %0d (now %0d)",
                 ev.eh_erro ? "erro" : "pronto", ev.borda, ciclo);
      end
      if (bus.pronto || bus.erro) begin
        check("pronto_erro_exclusive", 32'(bus.pronto & bus.erro), 32'd0);
        if (fila.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_event: got pronto=%0b erro=%0b expected none (cycle %0d)",
                   bus.pronto, bus.erro, ciclo);
        end else begin
          ev = fila.pop_front();
          check("event_kind_erro", 32'(bus.erro), 32'(ev.eh_erro));
          check("event_edge", 32'(ciclo), 32'(ev.borda));
          if (!ev.eh_erro) begin
            mon_c = ev.c; mon_d = ev.d; mon_u = ev.u;
          end
          check("centena", 32'(bus.centena), 32'(mon_c));
          check("dezena",  32'(bus.dezena),  32'(mon_d));
          check("unidade", 32'(bus.unidade), 32'(mon_u));
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         g;
    int         r;
    bus.dado_recebido = 8'h00;
    bus.recebido      = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_db_estado", 32'(bus.db_estado), 32'd0);
    check("rst_ocupado",   32'(bus.ocupado),   32'd0);
    check("rst_pronto",    32'(bus.pronto),    32'd0);
    check("rst_digits",    32'({bus.centena, bus.dezena, bus.unidade}), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // "407#" with strobes 10 cycles apart
    envia(8'h34, 9); check("ocupado_after_4", 32'(bus.ocupado), 32'd1);
    envia(8'h30, 9); check("ocupado_after_0", 32'(bus.ocupado), 32'd1);
    envia(8'h37, 9); check("db_estado_hashtag", 32'(bus.db_estado), 32'd3);
    envia(8'h23, 9); check("ocupado_after_frame", 32'(bus.ocupado), 32'd0);

    // bad second byte, then "123#"
    envia(8'h31, 2); envia(8'h41, 3);
    quadro(8'h31, 8'h32, 8'h33, 8'h23, 2);

    // early terminator, then leading '#' and "999#"
    envia(8'h31, 1); envia(8'h32, 1); envia(8'h23, 2);
    envia(8'h23, 1);
    quadro(8'h39, 8'h39, 8'h39, 8'h23, 1);

    // back-to-back frame, then a digit during the fim cycle
    quadro(8'h35, 8'h36, 8'h38, 8'h23, 0);
    envia(8'h39, 1);
    check("digit_in_fim_state", 32'(bus.db_estado), 32'd1);
    envia(8'h31, 0); envia(8'h32, 0); envia(8'h23, 3);

    // idle after one digit
    envia(8'h33, 1);
    ocioso(1000);
`ifdef RECEPCAO_TIMEOUT_EN
    check("idle_state", 32'(bus.db_estado), 32'd0);
`else
    check("idle_state", 32'(bus.db_estado), 32'd1);
`endif
    envia(8'h34, 1); envia(8'h35, 1); envia(8'h23, 3);

    // strobe exactly on the expiry edge, then one cycle too late
    envia(8'h36, T - 1); envia(8'h37, T); envia(8'h38, 2); envia(8'h23, 3);

    // randomized mix of frames, stray bytes and gaps around the timeout
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      g = (r < 4) ? 0 : (r < 8) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 20));
      if ($urandom_range(0, 9) < 5) begin
        quadro(8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9)),
               8'h30 + 8'($urandom_range(0, 9)), 8'h23, g);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 5)      b = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 8) b = 8'h23;
        else            b = 8'($urandom_range(0, 255));
        envia(b, g);
      end
    end
    ocioso(40);
    envia(8'h41, 5);
    check("queue_drained", 32'(fila.size()), 32'd0);

    // asynchronous reset mid-frame
    envia(8'h37, 2); envia(8'h37, 2);
    #2;
    reset = 1'b0;
    pend.delete();
    mon_c = 4'd0; mon_d = 4'd0; mon_u = 4'd0;
    #1;
    check("async_rst_db_estado", 32'(bus.db_estado), 32'd0);
    check("async_rst_ocupado",   32'(bus.ocupado),   32'd0);
    check("async_rst_erro",      32'(bus.erro),      32'd0);
    check("async_rst_digits",    32'({bus.centena, bus.dezena, bus.unidade}), 32'd0);
    repeat (2) @(negedge clock);
    check("rst_held_erro", 32'(bus.erro), 32'd0);
    reset = 1'b1;
    quadro(8'h32, 8'h34, 8'h36, 8'h23, 1);
    ocioso(5);
    check("final_queue_empty", 32'(fila.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
